// File: rtl/vld_rdy_arb.sv
// ---------------------------------------------------------------------------
// vld_rdy_arb
//
// Purpose:
//   N-way arbiter that lets several valid/ready masters share one registered
//   pipeline stage, e.g. DMI access and the abstract-command engine both
//   driving the system-bus port. Grants rotate round-robin. The output
//   register holds one entry, and a payload appears at the output one cycle
//   after it is accepted.
//
// Parameters:
//   N          number of requesters, 2..8
//   DW         payload width per requester
//   IW         width of id_o, must satisfy N <= 2**IW
//   CUT_READY  1: accept only into an empty stage (no rdy_i -> req_rdy_o path)
//              0: also accept on the cycle the stage is popped
//
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   req_vld_i   in   [N]     per-requester valid
//   req_rdy_o   out  [N]     per-requester ready, one-hot or zero
//   req_data_i  in   [N*DW]  packed payloads, requester i at [i*DW +: DW]
//   vld_o       out          output stage valid
//   rdy_i       in           downstream ready
//   data_o      out  [DW]    payload held in the stage
//   id_o        out  [IW]    index of the requester that owns the payload
//
// Configuration macro:
//   VLD_RDY_ARB_FIXED_PRIO_EN  when defined, the lowest valid index always
//                              wins and the rotating pointer is removed.
// ---------------------------------------------------------------------------
module vld_rdy_arb #(
   parameter int N         = 2,
   parameter int DW        = 32,
   parameter int IW        = 1,
   parameter int CUT_READY = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req_vld_i,
   output logic [N-1:0]    req_rdy_o,
   input  logic [N*DW-1:0] req_data_i,
   output logic            vld_o,
   input  logic            rdy_i,
   output logic [DW-1:0]   data_o,
   output logic [IW-1:0]   id_o
);

   // Reject configurations the id field or the arbiter cannot represent.
   if (N < 2 || N > 8) begin : g_bad_n
      $error("vld_rdy_arb: N must be in 2..8");
   end
   if (N > (1 << IW)) begin : g_bad_iw
      $error("vld_rdy_arb: IW too narrow for N requesters");
   end

   logic            vld_q, vld_d;
   logic [DW-1:0]   data_q, data_d;
   logic [IW-1:0]   id_q, id_d;

   logic [IW-1:0]   ptr;
   logic [N-1:0]    gntOh;
   logic [IW-1:0]   gntIdx;
   logic [DW-1:0]   gntData;
   logic            gntFound;
   int              scanIdx;
   logic            pop;
   logic            push;
   logic            stageRdy;

`ifdef VLD_RDY_ARB_FIXED_PRIO_EN
   // Fixed priority is round-robin with the scan always starting at index 0.
   assign ptr = '0;
`else
   logic [IW-1:0]   ptr_q, ptr_d;
   assign ptr = ptr_q;
`endif

   assign pop = vld_q & rdy_i;

   // CUT_READY=1 breaks the rdy_i -> req_rdy_o combinational path at the
   // cost of a bubble after every transfer.
   if (CUT_READY != 0) begin : g_cut
      assign stageRdy = ~vld_q;
   end else begin : g_pass
      assign stageRdy = ~vld_q | pop;
   end

   // Scan requesters starting at the pointer, wrapping at N, and take the
   // first valid one. The winning payload is selected in the same loop.
   always_comb begin
      gntOh    = '0;
      gntIdx   = '0;
      gntData  = '0;
      gntFound = 1'b0;
      scanIdx  = 0;
      for (int k = 0; k < N; k++) begin
         scanIdx = int'(ptr) + k;
         if (scanIdx >= N) begin
            scanIdx = scanIdx - N;
         end
         if (!gntFound && req_vld_i[scanIdx]) begin
            gntFound        = 1'b1;
            gntOh[scanIdx]  = 1'b1;
            gntIdx          = IW'(scanIdx);
            gntData         = req_data_i[scanIdx*DW +: DW];
         end
      end
   end

   // Ready is held low during reset so nothing is accepted while the stage
   // is being cleared.
   assign req_rdy_o = (rst_n && stageRdy) ? gntOh : '0;
   assign push      = |(req_vld_i & req_rdy_o);

   // A push reloads the stage (even when it is popped in the same cycle);
   // a bare pop only clears valid, leaving data and id untouched.
   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      id_d   = id_q;
      if (push) begin
         vld_d  = 1'b1;
         data_d = gntData;
         id_d   = gntIdx;
      end else if (pop) begin
         vld_d  = 1'b0;
      end
   end

   // Output stage register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         data_q <= '0;
         id_q   <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
         id_q   <= id_d;
      end
   end

`ifndef VLD_RDY_ARB_FIXED_PRIO_EN
   // The pointer only moves on a push, to the index just after the winner,
   // so a requester that is still waiting keeps its place in the rotation.
   always_comb begin
      ptr_d = ptr_q;
      if (push) begin
         ptr_d = (gntIdx == IW'(N-1)) ? '0 : gntIdx + IW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   assign vld_o  = vld_q;
   assign data_o = data_q;
   assign id_o   = id_q;

endmodule

// File: tb/tb_vld_rdy_arb.sv
// ---------------------------------------------------------------------------
// tb_vld_rdy_arb
//
// Purpose:
//   Directed bench for vld_rdy_arb. It uses three instances:
//     A: N=2, CUT_READY=0  (single push and two-way rotation)
//     B: N=4, CUT_READY=0  (rotation, back-pressure, reset mid-burst)
//     C: N=4, CUT_READY=1  (half-rate throughput)
//   When VLD_RDY_ARB_FIXED_PRIO_EN is defined, the expected ids switch to
//   fixed priority.
// ---------------------------------------------------------------------------
module tb_vld_rdy_arb;

`ifdef VLD_RDY_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   testsRun;
   int   testsFailed;

   logic [1:0]  aVld, aRdyO;
   logic [15:0] aData;
   logic        aVldO, aRdy;
   logic [7:0]  aDataO;
   logic [0:0]  aIdO;

   logic [3:0]  bVld, bRdyO;
   logic [31:0] bData;
   logic        bVldO, bRdy;
   logic [7:0]  bDataO;
   logic [1:0]  bIdO;

   logic [3:0]  cVld, cRdyO;
   logic [31:0] cData;
   logic        cVldO, cRdy;
   logic [7:0]  cDataO;
   logic [1:0]  cIdO;

   vld_rdy_arb #(.N(2), .DW(8), .IW(1), .CUT_READY(0)) dutA (
      .clk(clk), .rst_n(rst_n), .req_vld_i(aVld), .req_rdy_o(aRdyO),
      .req_data_i(aData), .vld_o(aVldO), .rdy_i(aRdy), .data_o(aDataO), .id_o(aIdO));

   vld_rdy_arb #(.N(4), .DW(8), .IW(2), .CUT_READY(0)) dutB (
      .clk(clk), .rst_n(rst_n), .req_vld_i(bVld), .req_rdy_o(bRdyO),
      .req_data_i(bData), .vld_o(bVldO), .rdy_i(bRdy), .data_o(bDataO), .id_o(bIdO));

   vld_rdy_arb #(.N(4), .DW(8), .IW(2), .CUT_READY(1)) dutC (
      .clk(clk), .rst_n(rst_n), .req_vld_i(cVld), .req_rdy_o(cRdyO),
      .req_data_i(cData), .vld_o(cVldO), .rdy_i(cRdy), .data_o(cDataO), .id_o(cIdO));

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge so registered outputs have settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      aVld = 2'b11; aRdy = 1'b1; aData = 16'h5AA5;
      bVld = 4'hF;  bRdy = 1'b1; bData = 32'h13121110;
      cVld = 4'hF;  cRdy = 1'b1; cData = 32'h23222120;
      tick();
      tick();
      testsRun++; if (aVldO !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_a_vld got %0h want 0", aVldO); end
      testsRun++; if (aRdyO !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_a_rdy got %0h want 0", aRdyO); end
      testsRun++; if (aDataO !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_a_data got %0h want 0", aDataO); end
      testsRun++; if (aIdO !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_a_id got %0h want 0", aIdO); end
      testsRun++; if (bVldO !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_b_vld got %0h want 0", bVldO); end
      testsRun++; if (bRdyO !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_b_rdy got %0h want 0", bRdyO); end
      testsRun++; if (cRdyO !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_c_rdy got %0h want 0", cRdyO); end
      aVld = 2'b00; aRdy = 1'b0;
      bVld = 4'h0;  bRdy = 1'b0;
      cVld = 4'h0;  cRdy = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_push();
      logic       expId;
      logic [7:0] expData;
      aData = 16'h5AA5;
      aVld  = 2'b01;
      aRdy  = 1'b1;
      #1;
      testsRun++; if (aRdyO !== 2'b01) begin testsFailed++; $display("[TB] FAIL single_rdy got %0h want 1", aRdyO); end
      tick();
      aVld = 2'b00;
      testsRun++; if (aVldO !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_vld got %0h want 1", aVldO); end
      testsRun++; if (aDataO !== 8'hA5) begin testsFailed++; $display("[TB] FAIL single_data got %0h want a5", aDataO); end
      testsRun++; if (aIdO !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_id got %0h want 0", aIdO); end
      tick();
      testsRun++; if (aVldO !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_pop_vld got %0h want 0", aVldO); end
      testsRun++; if (aDataO !== 8'hA5) begin testsFailed++; $display("[TB] FAIL single_pop_data got %0h want a5", aDataO); end
      // Both valid now: round-robin moved past requester 0, fixed priority did not.
      aVld = 2'b11;
      #1;
      testsRun++; if (aRdyO !== (FIXED ? 2'b01 : 2'b10)) begin testsFailed++; $display("[TB] FAIL two_way_rdy got %0h want %0h", aRdyO, FIXED ? 2'b01 : 2'b10); end
      expId   = FIXED ? 1'b0 : 1'b1;
      expData = FIXED ? 8'hA5 : 8'h5A;
      tick();
      aVld = 2'b00;
      testsRun++; if (aIdO !== expId) begin testsFailed++; $display("[TB] FAIL two_way_id got %0h want %0h", aIdO, expId); end
      testsRun++; if (aDataO !== expData) begin testsFailed++; $display("[TB] FAIL two_way_data got %0h want %0h", aDataO, expData); end
      tick();
   endtask

   task automatic test_round_robin();
      logic [1:0] expId;
      bData = 32'h13121110;
      bVld  = 4'hF;
      bRdy  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         expId = FIXED ? 2'd0 : 2'(k % 4);
         testsRun++; if (bVldO !== 1'b1) begin testsFailed++; $display("[TB] FAIL rr_vld[%0d] got %0h want 1", k, bVldO); end
         testsRun++; if (bIdO !== expId) begin testsFailed++; $display("[TB] FAIL rr_id[%0d] got %0h want %0h", k, bIdO, expId); end
         testsRun++; if (bDataO !== (8'h10 + 8'(expId))) begin testsFailed++; $display("[TB] FAIL rr_data[%0d] got %0h want %0h", k, bDataO, 8'h10 + 8'(expId)); end
      end
      // Requester 0 drops: fixed priority falls to 1, round-robin continues at 2.
      bVld = 4'hE;
      tick();
      expId = FIXED ? 2'd1 : 2'd2;
      testsRun++; if (bIdO !== expId) begin testsFailed++; $display("[TB] FAIL drop0_id got %0h want %0h", bIdO, expId); end
      bVld = 4'h0;
      tick();
      testsRun++; if (bVldO !== 1'b0) begin testsFailed++; $display("[TB] FAIL rr_drain_vld got %0h want 0", bVldO); end
   endtask

   task automatic test_back_pressure();
      bVld = 4'b0100;
      bRdy = 1'b0;
      tick();
      testsRun++; if (bVldO !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_fill_vld got %0h want 1", bVldO); end
      testsRun++; if (bDataO !== 8'h12) begin testsFailed++; $display("[TB] FAIL bp_fill_data got %0h want 12", bDataO); end
      bData[23:16] = 8'h77;
      for (int k = 0; k < 5; k++) begin
         tick();
         testsRun++; if (bVldO !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_vld[%0d] got %0h want 1", k, bVldO); end
         testsRun++; if (bDataO !== 8'h12) begin testsFailed++; $display("[TB] FAIL bp_data[%0d] got %0h want 12", k, bDataO); end
         testsRun++; if (bIdO !== 2'd2) begin testsFailed++; $display("[TB] FAIL bp_id[%0d] got %0h want 2", k, bIdO); end
         testsRun++; if (bRdyO !== 4'h0) begin testsFailed++; $display("[TB] FAIL bp_rdy[%0d] got %0h want 0", k, bRdyO); end
      end
      bRdy = 1'b1;
      #1;
      testsRun++; if (bRdyO !== 4'b0100) begin testsFailed++; $display("[TB] FAIL bp_release_rdy got %0h want 4", bRdyO); end
      tick();
      testsRun++; if (bVldO !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_refill_vld got %0h want 1", bVldO); end
      testsRun++; if (bDataO !== 8'h77) begin testsFailed++; $display("[TB] FAIL bp_refill_data got %0h want 77", bDataO); end
      bVld = 4'h0;
      bData[23:16] = 8'h12;
      tick();
      testsRun++; if (bVldO !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_drain_vld got %0h want 0", bVldO); end
   endtask

   task automatic test_cut_ready();
      logic       expV;
      logic [1:0] expId;
      cData = 32'h23222120;
      cVld  = 4'hF;
      cRdy  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         expV  = (k % 2 == 0);
         expId = FIXED ? 2'd0 : 2'((k / 2) % 4);
         testsRun++; if (cVldO !== expV) begin testsFailed++; $display("[TB] FAIL cut_vld[%0d] got %0h want %0h", k, cVldO, expV); end
         testsRun++; if (cIdO !== expId) begin testsFailed++; $display("[TB] FAIL cut_id[%0d] got %0h want %0h", k, cIdO, expId); end
         testsRun++; if (cDataO !== (8'h20 + 8'(expId))) begin testsFailed++; $display("[TB] FAIL cut_data[%0d] got %0h want %0h", k, cDataO, 8'h20 + 8'(expId)); end
         if (expV) begin
            testsRun++; if (cRdyO !== 4'h0) begin testsFailed++; $display("[TB] FAIL cut_rdy[%0d] got %0h want 0", k, cRdyO); end
         end
      end
      cVld = 4'h0;
      tick();
   endtask

   task automatic test_reset_mid_burst();
      // Push requester 1 so the round-robin pointer lands on 2.
      bVld = 4'b0010;
      bRdy = 1'b1;
      tick();
      testsRun++; if (bIdO !== 2'd1) begin testsFailed++; $display("[TB] FAIL mid_pre_id got %0h want 1", bIdO); end
      bVld = 4'hF;
      #2;
      rst_n = 1'b0;
      #1;
      testsRun++; if (bVldO !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_async_vld got %0h want 0", bVldO); end
      testsRun++; if (bIdO !== 2'd0) begin testsFailed++; $display("[TB] FAIL mid_async_id got %0h want 0", bIdO); end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      testsRun++; if (bVldO !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_first_vld got %0h want 1", bVldO); end
      testsRun++; if (bIdO !== 2'd0) begin testsFailed++; $display("[TB] FAIL mid_first_id got %0h want 0", bIdO); end
      testsRun++; if (bDataO !== 8'h10) begin testsFailed++; $display("[TB] FAIL mid_first_data got %0h want 10", bDataO); end
      bVld = 4'h0;
      tick();
   endtask

   // Run every scenario in order, then report.
   initial begin
      testsRun    = 0;
      testsFailed = 0;
      test_reset();
      test_single_push();
      test_round_robin();
      test_back_pressure();
      test_cut_ready();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
